fifo_thresh: RTL and testbench

Parametrised successor to the team's synchronous FIFO. Adds selectable show-ahead or registered-read mode, programmable almost-full and almost-empty thresholds, and write-through when full with a simultaneous read. Also adds a synchronous flush and sticky overflow/underflow error flags. Sits between CNN datapath stages (line buffers, weight/activation streams) where upstream back-pressure uses almost_full and downstream prefetch uses almost_empty.

---
 rtl/fifo_thresh.sv | 112 +++++++++++
 tb/tb_fifo_thresh.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with show-ahead or registered read, almost-full/almost-empty
// thresholds, write-through on full, flush and sticky overflow/underflow flags.
module fifo_thresh #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 512,
  parameter int WIDTHP    = $clog2(DEPTH) + 1,
  parameter bit SHOWAHEAD = 1'b1,
  parameter int AF_LEVEL  = DEPTH - 4,
  parameter int AE_LEVEL  = 4
) (
  input  logic              clock,
  input  logic              clock_sreset,
  input  logic              wrreq,
  input  logic [WIDTH-1:0]  data,
  input  logic              rdreq,
  input  logic              flush,
  input  logic              clear_errors,
  output logic [WIDTH-1:0]  q,
  output logic              rdvalid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [WIDTHP-1:0] usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = WIDTHP - 1;
  localparam logic [WIDTHP-1:0] FULL_LVL = WIDTHP'(DEPTH);
  localparam logic [WIDTHP-1:0] AF_LVL   = WIDTHP'(AF_LEVEL);
  localparam logic [WIDTHP-1:0] AE_LVL   = WIDTHP'(AE_LEVEL);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_params
      $error("fifo_thresh: DEPTH must be a power of two and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign empty        = (usedw == '0);
  assign full         = (usedw == FULL_LVL);
  assign almost_empty = (usedw <= AE_LVL);
  assign almost_full  = (usedw >= AF_LVL);

  // A write while full is legal only when the same cycle frees a slot.
  assign rd_acc = ~flush & rdreq & ~empty;
  assign wr_acc = ~flush & wrreq & (~full | rdreq);

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      usedw <= usedw + WIDTHP'(wr_acc) - WIDTHP'(rd_acc);
    end
  end

  // RAM has no reset; the old word at rd_ptr is read before this edge overwrites it.
  always_ff @(posedge clock) begin
    if (wr_acc && !clock_sreset) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (!flush && wrreq && !wr_acc) overflow <= 1'b1;
      else if (clear_errors)          overflow <= 1'b0;
      if (!flush && rdreq && !rd_acc) underflow <= 1'b1;
      else if (clear_errors)          underflow <= 1'b0;
    end
  end

  generate
    if (SHOWAHEAD) begin : g_showahead
      assign q       = mem[rd_ptr];
      assign rdvalid = ~empty;
    end else begin : g_registered
      logic [WIDTH-1:0] q_reg;
      logic             rdvalid_reg;

      always_ff @(posedge clock) begin
        if (clock_sreset) begin
          q_reg       <= '0;
          rdvalid_reg <= 1'b0;
        end else begin
          rdvalid_reg <= rd_acc;
          if (rd_acc) q_reg <= mem[rd_ptr];
        end
      end

      assign q       = q_reg;
      assign rdvalid = rdvalid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_thresh.sv
// Scoreboard bench: one show-ahead and one registered-read FIFO share stimulus;
// monitors pop expected read data whenever each DUT presents a word.
module tb_fifo_thresh;
  localparam int DEPTH = 8;
  localparam int WP    = 4;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          wrreq = 1'b0, rdreq = 1'b0, flush = 1'b0, clear_errors = 1'b0;
  logic [15:0]   data = '0;
  logic [15:0]   q_a, q_b;
  logic [WP-1:0] usedw_a, usedw_b;
  logic rdvalid_a, empty_a, full_a, ae_a, af_a, ov_a, un_a;
  logic rdvalid_b, empty_b, full_b, ae_b, af_b, ov_b, un_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] mq[$];
  logic [15:0] expa[$];
  logic [15:0] expb[$];
  bit m_ov = 0, m_un = 0;

  always #5 clock = ~clock;

  fifo_thresh #(.WIDTH(16), .DEPTH(DEPTH), .WIDTHP(WP), .SHOWAHEAD(1'b1),
                .AF_LEVEL(6), .AE_LEVEL(2)) dut_a (
    .clock(clock), .clock_sreset(rst), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .flush(flush), .clear_errors(clear_errors), .q(q_a), .rdvalid(rdvalid_a),
    .empty(empty_a), .full(full_a), .almost_empty(ae_a), .almost_full(af_a),
    .usedw(usedw_a), .overflow(ov_a), .underflow(un_a));

  fifo_thresh #(.WIDTH(16), .DEPTH(DEPTH), .WIDTHP(WP), .SHOWAHEAD(1'b0),
                .AF_LEVEL(6), .AE_LEVEL(2)) dut_b (
    .clock(clock), .clock_sreset(rst), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .flush(flush), .clear_errors(clear_errors), .q(q_b), .rdvalid(rdvalid_b),
    .empty(empty_b), .full(full_b), .almost_empty(ae_b), .almost_full(af_b),
    .usedw(usedw_b), .overflow(ov_b), .underflow(un_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Read-data monitors: show-ahead word is consumed on an accepted read,
  // registered word is presented while rdvalid is high.
  always @(negedge clock) begin
    if (rst === 1'b0 && flush === 1'b0 && rdreq === 1'b1 && empty_a === 1'b0) begin
      if (expa.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_a unexpected read actual=%0h required=none", q_a);
      end else chk("q_a", q_a, expa.pop_front());
    end
    if (rdvalid_b === 1'b1) begin
      if (expb.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_b unexpected rdvalid actual=%0h required=none", q_b);
      end else chk("q_b", q_b, expb.pop_front());
    end
  end

  task automatic check_state();
    chk("usedw_a", usedw_a, mq.size());
    chk("usedw_b", usedw_b, mq.size());
    chk("empty_a", empty_a, mq.size() == 0);
    chk("empty_b", empty_b, mq.size() == 0);
    chk("full_a", full_a, mq.size() == DEPTH);
    chk("ae_a", ae_a, mq.size() <= 2);
    chk("af_a", af_a, mq.size() >= 6);
    chk("af_b", af_b, mq.size() >= 6);
    chk("ovf_a", ov_a, m_ov);
    chk("ovf_b", ov_b, m_ov);
    chk("unf_a", un_a, m_un);
    chk("unf_b", un_b, m_un);
    chk("rdvalid_a", rdvalid_a, mq.size() != 0);
  endtask

  task automatic cyc(input bit w, input logic [15:0] d, input bit r, input bit f,
                     input bit c, input bit rs = 1'b0);
    logic [15:0] v;
    bit rok, wok;
    wrreq = w; data = d; rdreq = r; flush = f; clear_errors = c; rst = rs;
    if (rs) begin
      mq.delete(); m_ov = 0; m_un = 0;
    end else if (f) begin
      mq.delete();
      if (c) begin m_ov = 0; m_un = 0; end
    end else begin
      rok = r && (mq.size() > 0);
      wok = w && ((mq.size() < DEPTH) || r);
      if (rok) begin
        v = mq.pop_front();
        expa.push_back(v);
        expb.push_back(v);
      end
      if (wok) mq.push_back(d);
      if (w && !wok) m_ov = 1; else if (c) m_ov = 0;
      if (r && !rok) m_un = 1; else if (c) m_un = 0;
    end
    @(posedge clock);
    #1;
    wrreq = 0; rdreq = 0; flush = 0; clear_errors = 0; rst = 0;
    check_state();
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_ae", ae_a, 1);
    chk("rst_usedw", usedw_a, 0);
    chk("rst_rdvalid_b", rdvalid_b, 0);
    chk("rst_ovf", ov_b, 0);

    for (int i = 1; i <= 8; i++) begin
      cyc(1, 16'(i), 0, 0, 0);
      chk("fill_usedw", usedw_a, i);
      chk("fill_ae", ae_a, i <= 2);
      chk("fill_af", af_a, i >= 6);
      chk("fill_full", full_a, i == 8);
    end
    cyc(1, 16'h0009, 0, 0, 0);
    chk("ninth_ovf", ov_a, 1);
    chk("ninth_usedw", usedw_a, 8);

    for (int k = 0; k < 3; k++) begin
      cyc(1, 16'h00AA, 1, 0, 0);
      chk("wt_usedw", usedw_a, 8);
      chk("wt_ovf", ov_b, 1);
    end
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 0, 0);
    chk("drain_empty", empty_b, 1);
    cyc(0, 0, 0, 0, 1);
    chk("clr_ovf", ov_a, 0);

    cyc(1, 16'h1234, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("reg_rdvalid_t1", rdvalid_b, 1);
    chk("reg_q_t1", q_b, 16'h1234);
    cyc(0, 0, 0, 0, 0);
    chk("reg_rdvalid_t2", rdvalid_b, 0);
    chk("reg_q_hold", q_b, 16'h1234);
    cyc(0, 0, 1, 0, 0);
    chk("reg_unf_set", un_b, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reg_unf_clr", un_b, 0);

    for (int i = 0; i < 5; i++) cyc(1, 16'(16'h0010 + i), 0, 0, 0);
    cyc(1, 16'hDEAD, 0, 1, 0);
    chk("flush_usedw", usedw_a, 0);
    chk("flush_empty", empty_b, 1);
    chk("flush_ovf", ov_a, 0);
    cyc(1, 16'h0BEE, 0, 0, 0);
    chk("post_flush_head", q_a, 16'h0BEE);
    cyc(0, 0, 1, 0, 0);
    chk("post_flush_q_b", q_b, 16'h0BEE);

    cyc(1, 16'h0055, 1, 0, 0);
    chk("ewr_usedw", usedw_a, 1);
    chk("ewr_unf", un_a, 1);
    cyc(0, 0, 1, 0, 1);
    chk("ewr_clr", un_a, 0);

    for (int i = 0; i < 3 * DEPTH + 3; i++)
      cyc(1, 16'(16'h0100 + i), mq.size() >= 4, 0, 0);
    for (int k = 0; k < 2 * DEPTH && mq.size() > 0; k++) cyc(0, 0, 1, 0, 0);

    cyc(0, 0, 1, 0, 0);
    chk("pre_rst_unf", un_b, 1);
    cyc(1, 16'h0201, 0, 0, 0);
    cyc(1, 16'h0202, 1, 0, 0);
    cyc(1, 16'h0203, 0, 0, 0);
    cyc(1, 16'h0077, 0, 0, 0, 1);
    chk("mid_rst_usedw", usedw_b, 0);
    chk("mid_rst_q_b", q_b, 0);
    chk("mid_rst_rdvalid_b", rdvalid_b, 0);
    chk("mid_rst_unf", un_a, 0);
    chk("mid_rst_ae", ae_b, 1);
    chk("mid_rst_full", full_b, 0);

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("sb_a_left", expa.size(), 0);
    chk("sb_b_left", expb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
